// File: rtl/ga_resp_drain.sv
// ga_resp_drain
// -------------
// Core-side receiver for the GA coprocessor response path. One packed
// multivector result is captured per handshake and then drained to the
// core's register write-back port one WORD_W-bit word at a time. With
// SKIP_ZERO set, all-zero words are skipped, but the final word is always
// sent so the consumer still sees a wb_last_o beat. Error, overflow and
// underflow flags are reported on a separate one-cycle status pulse.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                abort the current drain and drop the captured result
//   resp_valid_i/ready_o   result handshake from the coprocessor
//   resp_result_i          packed multivector result (word 0 in the LSBs)
//   resp_rd_addr_i         destination register tag
//   resp_error_i,
//   resp_overflow_i,
//   resp_underflow_i       coprocessor status flags
//   wb_valid_o/ready_i     word transfer handshake to the write-back port
//   wb_data_o, wb_idx_o    word data and its index within the result
//   wb_last_o              final word of this result
//   wb_rd_addr_o           captured destination tag
//   stat_valid_o           one-cycle status pulse
//   stat_code_o            {error, overflow, underflow}
//   busy_o                 block is not idle
//   resp_cnt_o             completed results, wraps modulo 2^32

module ga_resp_drain #(
    parameter int MV_SIZE   = 512,
    parameter int WORD_W    = 32,
    parameter int SKIP_ZERO = 0,
    localparam int NUM_WORDS = MV_SIZE / WORD_W,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               resp_valid_i,
    output logic               resp_ready_o,
    input  logic [MV_SIZE-1:0] resp_result_i,
    input  logic [4:0]         resp_rd_addr_i,
    input  logic               resp_error_i,
    input  logic               resp_overflow_i,
    input  logic               resp_underflow_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [WORD_W-1:0]  wb_data_o,
    output logic [IDX_W-1:0]   wb_idx_o,
    output logic               wb_last_o,
    output logic [4:0]         wb_rd_addr_o,
    output logic               stat_valid_o,
    output logic [2:0]         stat_code_o,
    output logic               busy_o,
    output logic [31:0]        resp_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        STAT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t               state_q;
    state_t               state_d;

    logic [MV_SIZE-1:0]   result_q;
    logic [4:0]           rd_addr_q;
    logic                 err_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_WORDS-1:0] mask_q;
    logic [31:0]          resp_cnt_q;

    logic [NUM_WORDS-1:0] cap_mask;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [WORD_W-1:0]    words [NUM_WORDS];

    logic                 capture;
    logic                 word_accept;
    logic                 last_accept;
    logic                 cnt_inc;

    assign resp_ready_o = (state_q == IDLE) && !flush_i;
    assign capture      = resp_valid_i && resp_ready_o;
    assign word_accept  = (state_q == DRAIN) && wb_ready_i && !flush_i;
    assign last_accept  = word_accept && (idx_q == LAST_IDX);
    assign cnt_inc      = !flush_i &&
                          ((state_q == STAT) || (last_accept && !(ovf_q || unf_q)));

    // Mask of words that will be emitted for the incoming result. Without
    // zero-skipping every word qualifies. The top word is forced on so
    // every drain ends with a last beat, even for an all-zero result.
    always_comb begin
        cap_mask = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            cap_mask[k] = (SKIP_ZERO == 0) || (|resp_result_i[WORD_W*k +: WORD_W]);
        end
        cap_mask[NUM_WORDS-1] = 1'b1;
    end

    // Two priority encoders: the lowest qualifying word of the incoming
    // result (start of the drain), and the lowest qualifying word above the
    // current index (next beat). Scanning downwards lets the lowest hit win.
    // The top mask bit is always set, so both encoders always find a hit
    // whenever their result is actually used.
    always_comb begin
        first_idx = LAST_IDX;
        next_idx  = LAST_IDX;
        for (int k = NUM_WORDS - 1; k >= 0; k--) begin
            if (cap_mask[k]) begin
                first_idx = IDX_W'(k);
            end
            if (mask_q[k] && (k > int'(idx_q))) begin
                next_idx = IDX_W'(k);
            end
        end
    end

    // Next-state logic. Flush returns to IDLE from any state. An error
    // result skips the drain and goes straight to the status pulse. A
    // drain with overflow or underflow captured is followed by a status pulse.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_d = resp_error_i ? STAT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state_d = (ovf_q || unf_q) ? STAT : IDLE;
                    end
                end
                STAT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture registers, word index and completion counter. A flush does
    // not clear the captured data. Returning to IDLE is enough to discard
    // it, and the next capture overwrites it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q   <= '0;
            rd_addr_q  <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            idx_q      <= '0;
            mask_q     <= '0;
            resp_cnt_q <= '0;
        end else begin
            if (capture) begin
                result_q  <= resp_result_i;
                rd_addr_q <= resp_rd_addr_i;
                err_q     <= resp_error_i;
                ovf_q     <= resp_overflow_i;
                unf_q     <= resp_underflow_i;
                mask_q    <= cap_mask;
                idx_q     <= first_idx;
            end else if (word_accept && !last_accept) begin
                idx_q <= next_idx;
            end
            if (cnt_inc) begin
                resp_cnt_q <= resp_cnt_q + 32'd1;
            end
        end
    end

    // Split the captured result into words so the write-back data is a
    // plain array lookup by the current index.
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            words[k] = result_q[WORD_W*k +: WORD_W];
        end
    end

    assign wb_valid_o   = (state_q == DRAIN);
    assign wb_data_o    = words[idx_q];
    assign wb_idx_o     = idx_q;
    assign wb_last_o    = wb_valid_o && (idx_q == LAST_IDX);
    assign wb_rd_addr_o = rd_addr_q;
    assign stat_valid_o = (state_q == STAT);
    assign stat_code_o  = stat_valid_o ? {err_q, ovf_q, unf_q} : 3'b000;
    assign busy_o       = (state_q != IDLE);
    assign resp_cnt_o   = resp_cnt_q;

endmodule

// File: doc/ga_resp_drain.md
# ga_resp_drain

Core-side receiver for the GA coprocessor response path. Accepts one 512-bit result per handshake (`resp_valid_i`/`resp_ready_o`) and drains it to the core's 32-bit register write-back port as a sequence of word transfers. The sequence is 16 words by default, or fewer when zero-skipping is enabled. Error, overflow and underflow flags are reported on a separate status pulse. The block sits between the coprocessor result output and the Ibex write-back / GA store path.

## Interface
- `MV_SIZE`, 512: result width (`GA_MV_SIZE`); must be a multiple of `WORD_W`.
- `WORD_W`, 32: write-back word width.
- `SKIP_ZERO`, 0: when 1, all-zero words are not emitted, except the final word.
- Derived: `NUM_WORDS = MV_SIZE/WORD_W` (16); `IDX_W = $clog2(NUM_WORDS)` (4).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  abort the current drain and discard the captured result.
- `resp_valid_i`  in  1  coprocessor result valid.
- `resp_ready_o`  out  1  block can capture a result.
- `resp_result_i`  in  MV_SIZE  packed multivector result.
- `resp_rd_addr_i`  in  5  destination register tag.
- `resp_error_i`, `resp_overflow_i`, `resp_underflow_i`  in  1 each  coprocessor status flags.
- `wb_valid_o`  out  1  word transfer valid.
- `wb_ready_i`  in  1  consumer accepts the word.
- `wb_data_o`  out  WORD_W  word data.
- `wb_idx_o`  out  IDX_W  word index within the result.
- `wb_last_o`  out  1  final word of this result.
- `wb_rd_addr_o`  out  5  captured destination tag.
- `stat_valid_o`  out  1  one-cycle status pulse.
- `stat_code_o`  out  3  {error, overflow, underflow}.
- `busy_o`  out  1  state != IDLE.
- `resp_cnt_o`  out  32  count of completed results; wraps modulo 2^32.

## Operation
- FSM states: IDLE, DRAIN, STAT.
- `resp_ready_o = (state==IDLE) && !flush_i`.
- **IDLE:** on `resp_valid_i && resp_ready_o`:
  - Capture the result, `rd_addr` and the three flags.
  - If the error flag is set, go to STAT.
  - Otherwise set the index to the first emitted word and go to DRAIN.
- **Word mapping:** word k = `result[WORD_W*k +: WORD_W]`. Word 0 is the LSBs: {e23oi, e123oi}. Word 15 is {scalar, e1}.
- **Emitted-word selection:**
  - `SKIP_ZERO=0`: every index 0..NUM_WORDS-1, in ascending order.
  - `SKIP_ZERO=1`: only nonzero words, in ascending order, plus index NUM_WORDS-1, which is always emitted.
  - The next index is the lowest qualifying index above the current one, found by a priority encoder over a nonzero mask computed at capture.
- **DRAIN:**
  - `wb_valid_o=1`. `wb_last_o=1` iff index==NUM_WORDS-1.
  - On `wb_ready_i`, advance to the next index.
  - When the last word is accepted: if overflow or underflow was captured, go to STAT; else increment `resp_cnt_o` and go to IDLE.
- **STAT:**
  - `stat_valid_o=1` for exactly one cycle with `stat_code_o` = the captured flags.
  - Increment `resp_cnt_o`, then go to IDLE.
  - If error was set, no words are emitted for that result.
- **flush_i** (any state, highest priority after reset): next state is IDLE; no counter increment; no status pulse; the captured result is discarded. `wb_valid_o`/`stat_valid_o` fall on the next cycle.
- **rst_i:** state IDLE, index 0, captured registers 0, `resp_cnt_o=0`.

## Timing
- Reset values of all outputs: `wb_valid_o=0`, `wb_data_o=0`, `wb_idx_o=0`, `wb_last_o=0`, `wb_rd_addr_o=0`, `stat_valid_o=0`, `stat_code_o=0`, `busy_o=0`, `resp_cnt_o=0`. `resp_ready_o=1` while `flush_i=0`.
- Capture at cycle T → first word valid at T+1.
- With `wb_ready_i` held high, one word per cycle. A full drain takes cycles T+1..T+16, and `resp_ready_o` returns at T+17, or at T+18 when a STAT pulse occurs.
- Error path: capture at T → `stat_valid_o` at T+1 → IDLE at T+2.
- `wb_*` outputs are registered and held stable while `wb_valid_o && !wb_ready_i`. The consumer may stall indefinitely.
- `resp_cnt_o` updates the cycle after the completing handshake or pulse.
- Flush and resp handshake in the same cycle: no capture, because `resp_ready_o` is low.

## Test plan
- Reset, then a result with word k = 0x1000_0000+k, `SKIP_ZERO=0`, `wb_ready_i=1` → 16 words in consecutive cycles, idx 0..15, data 0x1000_0000..0x1000_000F; `wb_last_o` only on idx 15; `resp_cnt_o=1`.
- `SKIP_ZERO=1`, result nonzero only in words 3 and 9 → exactly three transfers: idx 3, 9, 15 (data 0); `wb_last_o` on idx 15.
- Error flag set with an arbitrary result → no `wb_valid_o`; one-cycle `stat_valid_o` with `stat_code_o=3'b100`; `resp_cnt_o` increments.
- Overflow+underflow set, `wb_ready_i` toggled 1,0,0,1… → data held stable through stalls; all 16 words delivered; then `stat_code_o=3'b011` pulse.
- `flush_i` asserted at word 5 → `wb_valid_o` low next cycle; `resp_cnt_o` unchanged; the next result drains from idx 0.
- Back-to-back results with `resp_valid_i` held high → the second capture occurs exactly at T+17; `resp_cnt_o` wraps from 0xFFFF_FFFF to 0 when preloaded via repeated results in a long run.
